instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage of the MIPS pipeline, directly upstream of the program memory ROM and feeding the IF/ID boundary.
- Owns the program counter, next-PC selection (sequential, branch, jump, jump-register), and the IF/ID pipeline register.
- Drives the ROM word-addressable byte offset combinationally and latches the returned instruction.
- Supports stall, flush and redirect from the hazard/decode logic.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instructions.
- TEXT_BASE, 32'h0040_0000, reset PC and byte address that maps to ROM word 0.
- MEMORY_DEPTH, 32, ROM depth in words; used only for the range check.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Stall_i  input  1  hold PC and IF/ID contents.
- Flush_i  input  1  replace IF/ID contents with a bubble on the next edge.
- Branch_i  input  1  taken-branch redirect from ID.
- BranchTarget_i  input  DATA_WIDTH  branch target byte address.
- Jump_i  input  1  j/jal redirect from ID.
- JumpIndex_i  input  26  instr_index field of the jump in ID.
- JumpReg_i  input  1  jr redirect from ID.
- JumpRegTarget_i  input  DATA_WIDTH  rs value for jr.
- Instruction_i  input  DATA_WIDTH  ROM read data.
- RomAddress_o  output  DATA_WIDTH  PC minus TEXT_BASE, to the ROM Address port.
- PC_o  output  DATA_WIDTH  current fetch PC.
- IFID_Instruction_o  output  DATA_WIDTH  latched instruction.
- IFID_PCPlus4_o  output  DATA_WIDTH  latched PC+4 of that instruction.
- IFID_Valid_o  output  1  1 = real instruction, 0 = bubble.
- AddrError_o  output  1  one-cycle pulse when a redirect target has a nonzero bits[1:0].
- OutOfRange_o  output  1  combinational; PC is outside [TEXT_BASE, TEXT_BASE+4*MEMORY_DEPTH).

Behaviour:
- Reset (async, reset==0):
  - PC = TEXT_BASE.
  - IFID_Instruction_o = 0 (NOP).
  - IFID_PCPlus4_o = 0.
  - IFID_Valid_o = 0.
  - AddrError_o = 0.
- Reset mid-operation aborts any redirect or stall immediately; there is no pending state.
- ROM read path is combinational:
  - RomAddress_o = PC_o - TEXT_BASE, modulo 2^DATA_WIDTH.
  - Instruction_i is sampled at the same edge the PC advances, so IF/ID latency is 1 cycle from PC.
- Redirect priority (ID-stage signals): JumpReg_i > Branch_i > Jump_i > sequential.
  - Jump target = {IFID_PCPlus4_o[31:28], JumpIndex_i, 2'b00}.
- Per rising edge, evaluated in order:
  1. Any redirect: PC <- selected target with bits[1:0] forced to 0. IF/ID <- bubble (Instruction 0, Valid 0, PCPlus4 0). This overrides Stall_i, because the redirect comes from an older instruction.
  2. Else if Stall_i:
     - PC holds.
     - If Flush_i is also high, IF/ID <- bubble; otherwise IF/ID holds.
  3. Else if Flush_i: PC <- PC+4 and IF/ID <- bubble.
  4. Else: PC <- PC+4, IF/ID_Instruction <- Instruction_i, IF/ID_PCPlus4 <- PC+4, Valid <- 1.
- PC+4 wraps modulo 2^DATA_WIDTH; there is no saturation.
- AddrError_o goes high for exactly the cycle after an edge that loaded a target with nonzero low bits; otherwise 0.
- OutOfRange_o does not alter sequencing; it is a debug flag only.
- Multiple redirect inputs asserted together are legal and resolved by the priority above; no error is flagged.

Decomposition:
- Shared package (fetch_pkg) holds:
  - TEXT_BASE default and NOP encoding (32'h0).
  - Next-PC select encoding: SEL_SEQ, SEL_JUMP, SEL_BRANCH, SEL_JR, SEL_HOLD.
- One sub-module, next_pc_select: purely combinational; takes PC, the redirect inputs and Stall_i; outputs the next PC, the select code and the misalign flag.
- PC register and IF/ID register stay in the top.

Test Plan:
- Reset then release, ROM word0=32'h2008_0005, word1=32'h2009_0003 -> PC_o 0x00400000, then 0x00400004 with IFID_Instruction_o 32'h2008_0005, PCPlus4 0x00400004, Valid 1; RomAddress_o 0x4.
- Stall_i high 2 cycles at PC 0x00400008 -> PC_o and IF/ID unchanged for 2 edges, then resume to 0x0040000C.
- Branch_i with target 0x00400020 while Stall_i=1 -> next PC 0x00400020 and IF/ID Valid 0; the following edge latches ROM word 8.
- Jump_i with IFID_PCPlus4_o 0x00400010 and JumpIndex_i 26'h0100003 -> PC 0x0040000C. JumpReg_i and Branch_i asserted together -> JR target wins.
- JumpReg_i target 0x00400006 -> PC 0x00400004 and AddrError_o high for one cycle. Sequential fetch past word 31 -> OutOfRange_o=1.
- reset low mid-stall with a pending branch -> all outputs immediately at reset values; PC 0x00400000 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: reset PC,
// bubble encoding and next-PC source codes.
package fetch_pkg;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JR     = 3'd3,
    SEL_HOLD   = 3'd4
  } next_pc_sel_e;

  function automatic logic is_redirect(input next_pc_sel_e sel);
    return (sel == SEL_JUMP) || (sel == SEL_BRANCH) || (sel == SEL_JR);
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Bundle between the fetch stage, the hazard/decode logic, the program ROM
// and the IF/ID consumers.
interface instruction_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  Stall_i;
  logic                  Flush_i;
  logic                  Branch_i;
  logic [DATA_WIDTH-1:0] BranchTarget_i;
  logic                  Jump_i;
  logic [25:0]           JumpIndex_i;
  logic                  JumpReg_i;
  logic [DATA_WIDTH-1:0] JumpRegTarget_i;
  logic [DATA_WIDTH-1:0] Instruction_i;
  logic [DATA_WIDTH-1:0] RomAddress_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] IFID_Instruction_o;
  logic [DATA_WIDTH-1:0] IFID_PCPlus4_o;
  logic                  IFID_Valid_o;
  logic                  AddrError_o;
  logic                  OutOfRange_o;

  modport master (
    input  Stall_i, Flush_i, Branch_i, BranchTarget_i, Jump_i, JumpIndex_i,
           JumpReg_i, JumpRegTarget_i, Instruction_i,
    output RomAddress_o, PC_o, IFID_Instruction_o, IFID_PCPlus4_o,
           IFID_Valid_o, AddrError_o, OutOfRange_o
  );

  modport slave (
    output Stall_i, Flush_i, Branch_i, BranchTarget_i, Jump_i, JumpIndex_i,
           JumpReg_i, JumpRegTarget_i, Instruction_i,
    input  RomAddress_o, PC_o, IFID_Instruction_o, IFID_PCPlus4_o,
           IFID_Valid_o, AddrError_o, OutOfRange_o
  );

endinterface

// File: rtl/next_pc_select.sv
// Combinational next-PC selection: JR > branch > jump > stall hold > sequential.
// Also flags redirect targets that are not word aligned.
module next_pc_select
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [3:0]            pc_region_i,
  input  logic                  stall_i,
  input  logic                  branch_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [25:0]           jump_index_i,
  input  logic                  jump_reg_i,
  input  logic [DATA_WIDTH-1:0] jump_reg_target_i,
  output logic [DATA_WIDTH-1:0] next_pc_o,
  output next_pc_sel_e          sel_o,
  output logic                  misalign_o
);

  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] raw_target;
  next_pc_sel_e          sel;

  // j/jal keeps the 256 MB region of the instruction in ID
  always_comb begin
    jump_target                    = '0;
    jump_target[DATA_WIDTH-1 -: 4] = pc_region_i;
    jump_target[27:0]              = {jump_index_i, 2'b00};
  end

  always_comb begin
    sel        = SEL_SEQ;
    raw_target = jump_target;
    if (jump_reg_i) begin
      sel        = SEL_JR;
      raw_target = jump_reg_target_i;
    end else if (branch_i) begin
      sel        = SEL_BRANCH;
      raw_target = branch_target_i;
    end else if (jump_i) begin
      sel        = SEL_JUMP;
    end else if (stall_i) begin
      sel        = SEL_HOLD;
    end
  end

  always_comb begin
    next_pc_o  = pc_i + DATA_WIDTH'(4);
    misalign_o = 1'b0;
    if (is_redirect(sel)) begin
      next_pc_o  = {raw_target[DATA_WIDTH-1:2], 2'b00};
      misalign_o = (raw_target[1:0] != 2'b00);
    end else if (sel == SEL_HOLD) begin
      next_pc_o  = pc_i;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: program counter, combinational ROM addressing and the
// IF/ID pipeline register with stall, flush and redirect handling.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT),
  parameter int                    MEMORY_DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_stage_if.master  bus
);

  localparam logic [DATA_WIDTH:0] TEXT_LIMIT =
    {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  addr_error_q, addr_error_d;

  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  next_pc_sel_e          sel;
  logic                  misalign;

  next_pc_select #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next_pc_select (
    .pc_i              (pc_q),
    .pc_region_i       (ifid_pc_plus4_q[DATA_WIDTH-1 -: 4]),
    .stall_i           (bus.Stall_i),
    .branch_i          (bus.Branch_i),
    .branch_target_i   (bus.BranchTarget_i),
    .jump_i            (bus.Jump_i),
    .jump_index_i      (bus.JumpIndex_i),
    .jump_reg_i        (bus.JumpReg_i),
    .jump_reg_target_i (bus.JumpRegTarget_i),
    .next_pc_o         (next_pc),
    .sel_o             (sel),
    .misalign_o        (misalign)
  );

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // A redirect squashes the fetched instruction even while stalled, since
  // it comes from an older instruction in ID.
  always_comb begin
    pc_d            = next_pc;
    addr_error_d    = misalign;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    if (is_redirect(sel) || bus.Flush_i) begin
      ifid_instr_d    = DATA_WIDTH'(NOP_INSTR);
      ifid_pc_plus4_d = '0;
      ifid_valid_d    = 1'b0;
    end else if (sel == SEL_SEQ) begin
      ifid_instr_d    = bus.Instruction_i;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= TEXT_BASE;
      ifid_instr_q    <= DATA_WIDTH'(NOP_INSTR);
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      addr_error_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      addr_error_q    <= addr_error_d;
    end
  end

  assign bus.RomAddress_o       = pc_q - TEXT_BASE;
  assign bus.PC_o               = pc_q;
  assign bus.IFID_Instruction_o = ifid_instr_q;
  assign bus.IFID_PCPlus4_o     = ifid_pc_plus4_q;
  assign bus.IFID_Valid_o       = ifid_valid_q;
  assign bus.AddrError_o        = addr_error_q;
  assign bus.OutOfRange_o       = (pc_q < TEXT_BASE) || ({1'b0, pc_q} >= TEXT_LIMIT);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed scenarios followed by
// random stall/flush/redirect traffic against a behavioural fetch model.
module tb_instruction_fetch_stage;

  localparam int          DW    = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_compared = 0;
  int   n_mismatched = 0;

  logic [31:0] rom [DEPTH];
  exp_t        exp_q [$];

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;

  instruction_fetch_stage_if #(.DATA_WIDTH(DW)) bus ();

  instruction_fetch_stage #(
    .DATA_WIDTH   (DW),
    .TEXT_BASE    (BASE),
    .MEMORY_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM stand-in: real words inside the text segment, a recognisable
  // address-derived pattern outside it
  always_comb begin
    if (bus.RomAddress_o < 32'(4 * DEPTH)) bus.Instruction_i = rom[bus.RomAddress_o[6:2]];
    else                                   bus.Instruction_i = 32'hFACE_0000 ^ bus.RomAddress_o;
  end

  function automatic logic [31:0] rom_read(input logic [31:0] offset);
    if (offset < 32'(4 * DEPTH)) return rom[offset[6:2]];
    return 32'hFACE_0000 ^ offset;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_compared++;
    if (act !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.err = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = BASE; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji, input logic jr, input logic [31:0] jrt);
    bus.Stall_i = st; bus.Flush_i = fl;
    bus.Branch_i = br; bus.BranchTarget_i = bt;
    bus.Jump_i = j; bus.JumpIndex_i = ji;
    bus.JumpReg_i = jr; bus.JumpRegTarget_i = jrt;
  endtask

  // One clock of stimulus: drive, advance the reference model, queue the
  // expectation for the coming edge, and return on the following negedge.
  task automatic applyStimulus(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                               input logic j, input logic [25:0] ji, input logic jr, input logic [31:0] jrt);
    logic [31:0] tgt;
    drive(st, fl, br, bt, j, ji, jr, jrt);
    if (jr)      tgt = jrt;
    else if (br) tgt = bt;
    else         tgt = {m_pc4[31:28], ji, 2'b00};
    if (jr || br || j) begin
      m_err = (tgt % 4) != 0;
      m_pc  = tgt - (tgt % 4);
      model_bubble();
    end else begin
      m_err = 1'b0;
      if (st) begin
        if (fl) model_bubble();
      end else begin
        if (fl) model_bubble();
        else begin
          m_instr = rom_read(m_pc - BASE);
          m_pc4   = m_pc + 4;
          m_valid = 1'b1;
        end
        m_pc = m_pc + 4;
      end
    end
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hold_reset_cycle();
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_pc", bus.PC_o, BASE);
    checkOutput("rst_rom_addr", bus.RomAddress_o, 32'h0);
    checkOutput("rst_instr", bus.IFID_Instruction_o, 32'h0);
    checkOutput("rst_pc4", bus.IFID_PCPlus4_o, 32'h0);
    checkOutput("rst_valid", 32'(bus.IFID_Valid_o), 32'h0);
    checkOutput("rst_err", 32'(bus.AddrError_o), 32'h0);
  endtask

  // Monitor: every edge with an outstanding expectation is checked
  initial begin
    exp_t e;
    logic oor;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        oor = (e.pc < BASE) || ({1'b0, e.pc} >= ({1'b0, BASE} + 33'(4 * DEPTH)));
        checkOutput("pc", bus.PC_o, e.pc);
        checkOutput("rom_addr", bus.RomAddress_o, e.pc - BASE);
        checkOutput("ifid_instr", bus.IFID_Instruction_o, e.instr);
        checkOutput("ifid_pc4", bus.IFID_PCPlus4_o, e.pc4);
        checkOutput("ifid_valid", 32'(bus.IFID_Valid_o), 32'(e.valid));
        checkOutput("addr_error", 32'(bus.AddrError_o), 32'(e.err));
        checkOutput("out_of_range", 32'(bus.OutOfRange_o), 32'(oor));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        st, fl, br, j, jr;
    logic [31:0] bt, jrt;
    logic [25:0] ji;
    int          wait_cycles;

    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom();
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0003;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    #1 reset = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    hold_reset_cycle();
    reset = 1'b1;

    // Sequential fetch of words 0 and 1
    idle(2);
    // Two-cycle stall at 0x00400008, then resume
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Branch overrides a concurrent stall, then word 8 is fetched
    applyStimulus(1, 0, 1, BASE + 32'h20, 0, 0, 0, 0);
    idle(1);
    // Jump into word 3; JR beats a simultaneous branch
    applyStimulus(0, 0, 0, 0, 1, 26'h0100003, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, BASE + 32'h30, 0, 0, 1, BASE + 32'h10);
    // Misaligned JR target is truncated and flagged for one cycle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, BASE + 32'h6);
    idle(2);
    // Flush alone, then stall together with flush
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    // Run off the end of the ROM
    applyStimulus(0, 0, 1, BASE + 32'h78, 0, 0, 0, 0);
    idle(4);

    // Asynchronous reset in the middle of a stalled cycle with a branch pending
    drive(1, 0, 1, BASE + 32'h40, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    hold_reset_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1 checkOutput("pc_after_release", bus.PC_o, BASE);
    idle(2);

    // Random traffic, occasionally jumping to the top of the address space
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 10);
      br  = ($urandom_range(0, 99) < 8);
      j   = ($urandom_range(0, 99) < 5);
      jr  = ($urandom_range(0, 99) < 5);
      bt  = BASE + $urandom_range(0, 150);
      ji  = 26'((BASE >> 2) + $urandom_range(0, 40));
      jrt = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFF8 : BASE + $urandom_range(0, 150);
      applyStimulus(st, fl, br, bt, j, ji, jr, jrt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
